// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store funct3 encodings and the LSU state enum.
package cpu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/cpu_lsu_align.sv
// Byte-lane steering for the LSU: strobes, lane-replicated store data and the
// misaligned/illegal-control flag, all derived from funct3 and the byte offset.
module cpu_lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  control_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic        err_o
);

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = wdata_i;
        err_o   = 1'b0;
        case (control_i)
            LS_B, LS_BU: begin
                wstrb_o = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            LS_H, LS_HU: begin
                wstrb_o = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                err_o   = off_i[0];
            end
            LS_W: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
                err_o   = |off_i;
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit: one operation in flight, word-aligned bus access with byte
// strobes, load data returned right-shifted with the latched funct3.
module cpu_lsu
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_control,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [2:0]            rsp_control,
    output logic                  rsp_err
);

    lsu_state_e            state_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            control_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic [3:0]            align_wstrb;
    logic [31:0]           align_wdata;
    logic                  align_err;
    logic [31:0]           rdata_shifted;

    // Alignment is evaluated on the incoming request so the strobes and
    // replicated data can be registered at accept time.
    cpu_lsu_align u_align (
        .control_i (req_control),
        .off_i     (req_addr[1:0]),
        .wdata_i   (req_wdata),
        .wstrb_o   (align_wstrb),
        .wdata_o   (align_wdata),
        .err_o     (align_err)
    );

    assign rdata_shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            control_q <= 3'b000;
            wstrb_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        control_q <= req_control;
                        wstrb_q   <= align_wstrb;
                        wdata_q   <= align_wdata;
                        rdata_q   <= 32'h0;
                        err_q     <= align_err;
                        state_q   <= align_err ? ST_RESP : ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (mem_ready) begin
                        if (we_q) begin
                            state_q <= ST_RESP;
                        end else if (mem_rvalid) begin
                            rdata_q <= rdata_shifted;
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= rdata_shifted;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register so reset
    // removes mem_valid/rsp_valid without waiting for a clock edge.
    assign req_ready   = (state_q == ST_IDLE);
    assign mem_valid   = (state_q == ST_BUS);
    assign rsp_valid   = (state_q == ST_RESP);
    assign mem_we      = we_q;
    assign mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wstrb   = wstrb_q;
    assign mem_wdata   = wdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_control = control_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// Self-checking bench for cpu_lsu: scripted bus/consumer timing per operation,
// expectations queued when a request is driven and popped when the DUT answers.
module tb_cpu_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_control = 3'b000;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_control;
    logic        rsp_err;

    cpu_lsu #(.ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_control (req_control),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_control (rsp_control),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        we;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  ctrl;
        logic        err;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [2:0] ctrl, input logic [1:0] off);
        case (ctrl)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return off[0];
            3'b010:         return (off != 2'b00);
            default:        return 1'b1;
        endcase
    endfunction

    function automatic bus_t model_bus(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [2:0] ctrl);
        bus_t b;
        b.addr = {addr[31:2], 2'b00};
        b.we   = we;
        case (ctrl)
            3'b000, 3'b100: begin
                b.wstrb = 4'(4'b0001 << addr[1:0]);
                b.wdata = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
            end
            3'b001, 3'b101: begin
                b.wstrb = (addr[1] ? 4'b1100 : 4'b0011);
                b.wdata = {wdata[15:0], wdata[15:0]};
            end
            default: begin
                b.wstrb = 4'b1111;
                b.wdata = wdata;
            end
        endcase
        return b;
    endfunction

    // One full operation: accept, bus phase (rdy cycles of mem_ready low),
    // read-data delay rv cycles after mem_ready, then rdly cycles of rsp backpressure.
    task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] ctrl, input logic [31:0] word,
                         input int rdy, input int rv, input int rdly);
        bus_t eb;
        rsp_t er;
        int   cyc;
        int   exp_lat;
        int   guard;
        logic err;

        err      = model_err(ctrl, addr[1:0]);
        er.ctrl  = ctrl;
        er.err   = err;
        er.rdata = (err || we) ? 32'h0 : (word >> (8 * addr[1:0]));
        rsp_q.push_back(er);
        if (!err) bus_q.push_back(model_bus(we, addr, wdata, ctrl));
        if (err)      exp_lat = 1;
        else if (we)  exp_lat = rdy + 2;
        else          exp_lat = rdy + 2 + rv;

        @(negedge clk);
        req_valid   = 1'b1;
        req_we      = we;
        req_addr    = addr;
        req_wdata   = wdata;
        req_control = ctrl;
        chk("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        cyc = 1;
        req_valid = 1'b0;
        mem_rdata = ~word;

        if (err) begin
            chk("err_no_mem_valid", mem_valid, 1'b0);
        end else begin
            if (bus_q.size() == 0) begin
                chk("bus_queue_empty", 32'd0, 32'd1);
                eb = model_bus(we, addr, wdata, ctrl);
            end else begin
                eb = bus_q.pop_front();
            end
            for (int i = 0; i <= rdy; i++) begin
                chk("mem_valid", mem_valid, 1'b1);
                chk("mem_addr", mem_addr, eb.addr);
                chk("mem_wstrb", mem_wstrb, eb.wstrb);
                chk("mem_wdata", mem_wdata, eb.wdata);
                chk("mem_we", mem_we, eb.we);
                chk("req_ready_busy", req_ready, 1'b0);
                if (i == rdy) begin
                    mem_ready = 1'b1;
                    if (!we && rv == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = word;
                    end
                end
                @(posedge clk);
                cyc++;
                @(negedge clk);
                mem_ready  = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata  = ~word;
            end
            if (!we) begin
                for (int j = 1; j <= rv; j++) begin
                    chk("wait_mem_valid", mem_valid, 1'b0);
                    chk("wait_rsp_valid", rsp_valid, 1'b0);
                    if (j == rv) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = word;
                    end
                    @(posedge clk);
                    cyc++;
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                    mem_rdata  = ~word;
                end
            end
        end

        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            guard++;
        end
        chk("rsp_valid_timeout", rsp_valid, 1'b1);
        chk("rsp_latency", cyc, exp_lat);

        if (rsp_q.size() == 0) begin
            chk("rsp_queue_empty", 32'd0, 32'd1);
        end else begin
            er = rsp_q.pop_front();
            for (int k = 0; k <= rdly; k++) begin
                chk("rsp_valid_hold", rsp_valid, 1'b1);
                chk("rsp_rdata", rsp_rdata, er.rdata);
                chk("rsp_control", rsp_control, er.ctrl);
                chk("rsp_err", rsp_err, er.err);
                chk("resp_req_ready", req_ready, 1'b0);
                chk("resp_mem_valid", mem_valid, 1'b0);
                if (k == rdly) rsp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rsp_ready = 1'b0;
            end
        end
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_req_ready", req_ready, 1'b1);
        $display("op we=%0d addr=0x%08h ctrl=%03b exp_rdata=0x%08h err=%0d lat=%0d",
                 we, addr, ctrl, er.rdata, er.err, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_wstrb", mem_wstrb, 4'b0000);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1'b1, 32'h0000_1003, 32'h0000_00AB, 3'b000, 32'h0, 0, 0, 0);
        do_op(1'b0, 32'h0000_2002, 32'h0, 3'b101, 32'hBEEF_1234, 0, 0, 0);
        do_op(1'b0, 32'h0000_2000, 32'h0, 3'b010, 32'hDEAD_BEEF, 0, 3, 0);
        do_op(1'b0, 32'h0000_3001, 32'h0, 3'b010, 32'h1111_1111, 0, 0, 0);
        do_op(1'b1, 32'h0000_3003, 32'h0000_1234, 3'b001, 32'h0, 0, 0, 0);
        do_op(1'b0, 32'h0000_3000, 32'h0, 3'b011, 32'h2222_2222, 0, 0, 0);
        do_op(1'b0, 32'h0000_3000, 32'h0, 3'b111, 32'h2222_2222, 0, 0, 0);
        do_op(1'b0, 32'h0000_4000, 32'h0, 3'b010, 32'hCAFE_F00D, 4, 0, 5);
        do_op(1'b1, 32'h0000_4002, 32'h0000_5678, 3'b001, 32'h0, 4, 0, 5);
        do_op(1'b0, 32'h0000_4003, 32'h0, 3'b100, 32'h80FF_7F01, 2, 2, 1);

        // Reset while the bus request is outstanding.
        @(negedge clk);
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_addr    = 32'h0000_5004;
        req_control = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("prereset_mem_valid", mem_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_valid", mem_valid, 1'b0);
        chk("arst_req_ready", req_ready, 1'b1);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_mem_wstrb", mem_wstrb, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_req_ready", req_ready, 1'b1);
        chk("postrst_mem_valid", mem_valid, 1'b0);
        $display("op reset during BUS: transaction discarded");
        do_op(1'b0, 32'h0000_5006, 32'h0, 3'b001, 32'hA5A5_C3C3, 0, 1, 0);

        for (int n = 0; n < 12; n++) begin
            do_op(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                  $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        chk("bus_queue_drained", bus_q.size(), 32'd0);
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
